// File: rtl/sd_join_pkg.sv
// Shared helpers for the synchronising join: saturating increment for the skew counters.
package sd_join_pkg;

  localparam int SKEW_W_DEF = 8;
  localparam logic [31:0] SKEW_SAT = 32'hFFFF_FFFF;

  // Increment that sticks at the all-ones value of a width-bit counter (width 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_v;
    max_v = SKEW_SAT >> (32 - width);
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/sd_join_slot.sv
// One-entry holding slot for a join branch; accepts a new item in the same cycle the slot drains.
// Latency: 1 cycle in to slot; backpressure: c_drdy low while full and not draining.
module sd_join_slot
  import sd_join_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_srdy,
  input  logic [width-1:0] c_data,
  input  logic             fire,
  output logic             c_drdy,
  output logic             slot_vld,
  output logic [width-1:0] slot_data
);

  logic ld;

  assign c_drdy = ~slot_vld | fire;
  assign ld     = c_srdy & c_drdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld  <= 1'b0;
      slot_data <= '0;
    end else if (ld) begin
      slot_vld  <= 1'b1;
      slot_data <= c_data;
    end else if (fire) begin
      slot_vld  <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst)
    !(ld && slot_vld && !fire));
`endif

endmodule

// File: rtl/sd_join.sv
// Synchronising join: concatenates one item from every branch into a registered output word.
// Latency 2 cycles from last branch presented; c_drdy follows p_drdy combinationally when slots are full.
module sd_join_sync
  import sd_join_pkg::*;
#(
  parameter int join_cnt = 2,
  parameter int width    = 32,
  parameter int skew_w   = SKEW_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [join_cnt-1:0]       c_srdy,
  output logic [join_cnt-1:0]       c_drdy,
  input  logic [join_cnt*width-1:0] c_data,
  output logic                      p_srdy,
  input  logic                      p_drdy,
  output logic [join_cnt*width-1:0] p_data,
  input  logic                      skew_clr,
  output logic [skew_w-1:0]         skew_max
);

  logic [join_cnt-1:0]       slot_vld;
  logic [join_cnt*width-1:0] slot_cat;
  logic                      all_vld;
  logic                      out_free;
  logic                      fire;
  logic                      partial;
  logic [skew_w-1:0]         skew_cnt;

  assign all_vld  = &slot_vld;
  assign out_free = ~p_srdy | p_drdy;
  assign fire     = all_vld & out_free;
  assign partial  = (|slot_vld) & ~all_vld;

  for (genvar i = 0; i < join_cnt; i++) begin : g_slot
    sd_join_slot #(.width(width)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .c_srdy   (c_srdy[i]),
      .c_data   (c_data[i*width +: width]),
      .fire     (fire),
      .c_drdy   (c_drdy[i]),
      .slot_vld (slot_vld[i]),
      .slot_data(slot_cat[i*width +: width])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_srdy <= 1'b0;
      p_data <= '0;
    end else if (fire) begin
      p_srdy <= 1'b1;
      p_data <= slot_cat;
    end else if (p_drdy) begin
      p_srdy <= 1'b0;
    end
  end

  // skew_cnt is nonzero only right after a partial run, so folding it in whenever
  // partial is low captures the run length on the falling cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skew_cnt <= '0;
      skew_max <= '0;
    end else begin
      if (partial)
        skew_cnt <= skew_w'(sat_inc(32'(skew_cnt), skew_w));
      else
        skew_cnt <= '0;

      if (skew_clr)
        skew_max <= '0;
      else if (!partial && (skew_cnt > skew_max))
        skew_max <= skew_cnt;
    end
  end

`ifndef SYNTHESIS
  a_out_stable: assert property (@(posedge clk) disable iff (!rst)
    (p_srdy && !p_drdy) |=> (p_srdy && $stable(p_data)));
`endif

endmodule

// File: tb/tb_sd_join_sync.sv
// Directed bench for sd_join_sync with two 8-bit branches and a 3-bit skew monitor.
module tb_sd_join_sync;

  logic        clk;
  logic        rst;
  logic [1:0]  c_srdy;
  logic [1:0]  c_drdy;
  logic [15:0] c_data;
  logic        p_srdy;
  logic        p_drdy;
  logic [15:0] p_data;
  logic        skew_clr;
  logic [2:0]  skew_max;

  int n_chk;
  int n_pass;

  sd_join_sync #(.join_cnt(2), .width(8), .skew_w(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .c_srdy  (c_srdy),
    .c_drdy  (c_drdy),
    .c_data  (c_data),
    .p_srdy  (p_srdy),
    .p_drdy  (p_drdy),
    .p_data  (p_data),
    .skew_clr(skew_clr),
    .skew_max(skew_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance to just after the next rising edge, then let inputs/outputs settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst      = 1'b0;
    c_srdy   = 2'b00;
    c_data   = 16'h0000;
    p_drdy   = 1'b1;
    skew_clr = 1'b0;

    // reset state
    repeat (3) cyc();
    settle();
    check("rst_p_srdy", 32'(p_srdy), 32'h0);
    check("rst_p_data", 32'(p_data), 32'h0);
    check("rst_skew_max", 32'(skew_max), 32'h0);
    cyc();
    rst = 1'b1;
    settle();
    check("rst_c_drdy", 32'(c_drdy), 32'h3);

    // 1: both branches together, two-cycle latency
    cyc();
    c_srdy = 2'b11; c_data = 16'hB2A1;
    cyc();
    c_srdy = 2'b00;
    settle();
    check("t1_lat_p_srdy_early", 32'(p_srdy), 32'h0);
    cyc();
    settle();
    check("t1_p_srdy", 32'(p_srdy), 32'h1);
    check("t1_p_data", 32'(p_data), 32'hB2A1);
    check("t1_skew_max", 32'(skew_max), 32'h0);
    cyc();
    settle();
    check("t1_p_srdy_drop", 32'(p_srdy), 32'h0);

    // 2: branch1 five cycles late; branch0 re-offers and is held off
    c_srdy = 2'b01; c_data = 16'h0011;
    cyc();
    c_data = 16'h0055;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        c_srdy = 2'b11; c_data = 16'h2255;
      end
      settle();
      check("t2_c_drdy0_held", 32'(c_drdy[0]), 32'h0);
      cyc();
    end
    c_srdy = 2'b01; c_data = 16'h0055;
    settle();
    check("t2_c_drdy_fire", 32'(c_drdy), 32'h3);
    cyc();
    c_srdy = 2'b10; c_data = 16'h6600;
    settle();
    check("t2_p_data", 32'(p_data), 32'h2211);
    check("t2_skew_max", 32'(skew_max), 32'h5);
    cyc();
    c_srdy = 2'b00;
    cyc();
    settle();
    check("t2_next_p_data", 32'(p_data), 32'h6655);
    check("t2_skew_keep", 32'(skew_max), 32'h5);
    cyc();

    // 3: continuous stream, one word per cycle in order
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        c_srdy = 2'b11; c_data = {8'(8'h80 + i), 8'(i)};
      end else begin
        c_srdy = 2'b00;
      end
      settle();
      if (i < 8)
        check("t3_c_drdy", 32'(c_drdy), 32'h3);
      if (i >= 2) begin
        check("t3_p_srdy", 32'(p_srdy), 32'h1);
        check("t3_p_data", 32'(p_data), 32'({8'(8'h80 + i - 2), 8'(i - 2)}));
      end
      cyc();
    end
    c_srdy = 2'b00;
    settle();
    check("t3_idle", 32'(p_srdy), 32'h0);

    // 4: output stalled with both slots full
    p_drdy = 1'b0;
    c_srdy = 2'b11; c_data = 16'h0201;
    cyc();
    c_data = 16'h0403;
    cyc();
    c_data = 16'h0605;
    for (int j = 0; j < 10; j++) begin
      settle();
      check("t4_c_drdy", 32'(c_drdy), 32'h0);
      check("t4_p_data_stable", 32'(p_data), 32'h0201);
      if (j < 9) cyc();
    end
    cyc();
    p_drdy = 1'b1;
    settle();
    check("t4_release_drdy", 32'(c_drdy), 32'h3);
    cyc();
    c_srdy = 2'b00;
    settle();
    check("t4_word_b", 32'(p_data), 32'h0403);
    cyc();
    settle();
    check("t4_word_c", 32'(p_data), 32'h0605);
    cyc();
    settle();
    check("t4_drain", 32'(p_srdy), 32'h0);

    // 5: branch1 twelve cycles late saturates the 3-bit monitor
    c_srdy = 2'b01; c_data = 16'h0077;
    cyc();
    c_srdy = 2'b00;
    repeat (11) cyc();
    c_srdy = 2'b10; c_data = 16'h8800;
    cyc();
    c_srdy = 2'b00;
    cyc();
    settle();
    check("t5_p_data", 32'(p_data), 32'h8877);
    check("t5_skew_sat", 32'(skew_max), 32'h7);
    skew_clr = 1'b1;
    cyc();
    skew_clr = 1'b0;
    settle();
    check("t5_skew_clr", 32'(skew_max), 32'h0);

    // 6: reset with slot0 full discards it
    c_srdy = 2'b01; c_data = 16'h0099;
    cyc();
    c_srdy = 2'b00;
    settle();
    rst = 1'b0;
    #1;
    check("t6_async_p_data", 32'(p_data), 32'h0);
    check("t6_async_p_srdy", 32'(p_srdy), 32'h0);
    check("t6_async_c_drdy", 32'(c_drdy), 32'h3);
    cyc();
    rst = 1'b1;
    c_srdy = 2'b10; c_data = 16'h4400;
    cyc();
    c_srdy = 2'b00;
    cyc();
    settle();
    check("t6_no_stale_fire", 32'(p_srdy), 32'h0);
    c_srdy = 2'b01; c_data = 16'h0033;
    cyc();
    c_srdy = 2'b00;
    cyc();
    settle();
    check("t6_p_srdy", 32'(p_srdy), 32'h1);
    check("t6_p_data", 32'(p_data), 32'h4433);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_join_sync.md
Name: sd_join_sync

Overview:
- Synchronising join that re-aligns N parallel branches into one transaction. The branches fan out from an atomic mirror and then pass through independent processing paths of differing latency.
- Each input has a one-entry holding slot. When every slot is occupied, the slots are concatenated into a registered output word and all slots drain in the same cycle.
- It sits directly downstream of the mirror's processing branches and restores the one-in/one-out transaction ordering.
- A saturating skew monitor reports the worst-case branch misalignment for performance debug.

Parameters:
- join_cnt, 2, number of input branches (>=2).
- width, 32, data width per branch.
- skew_w, 8, width of the skew counters (saturating).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- c_srdy  input  join_cnt  per-branch source ready.
- c_drdy  output  join_cnt  per-branch destination ready.
- c_data  input  join_cnt*width  branch i occupies bits [i*width +: width].
- p_srdy  output  1  joined word valid (registered).
- p_drdy  input  1  consumer ready.
- p_data  output  join_cnt*width  joined word, same packing as c_data (registered).
- skew_clr  input  1  synchronous clear of skew_max.
- skew_max  output  skew_w  maximum observed partial-occupancy wait, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - all slot_vld=0, p_srdy=0, p_data=0, skew_cnt=0, skew_max=0.
  - c_drdy=all ones once reset deasserts (slots empty).
- Slot i state: slot_vld[i], slot_data[i].
- all_vld = &slot_vld.
- out_free = ~p_srdy | p_drdy.
- fire = all_vld & out_free.
- c_drdy[i] = ~slot_vld[i] | fire.
  - Combinational path from p_drdy to c_drdy is intentional; the codebase wraps the output with sd_output when closure is needed.
- Slot update per cycle, with ld_i = c_srdy[i] & c_drdy[i]:
  - ld_i=1: slot_vld[i]<=1, slot_data[i]<=c_data[i]. Covers load-while-draining.
  - ld_i=0 and fire=1: slot_vld[i]<=0.
  - Otherwise: hold.
- Output register:
  - fire=1: p_srdy<=1, p_data<=concat(slot_data).
  - fire=0 and p_drdy=1: p_srdy<=0.
  - Otherwise: hold.
  - p_data is unchanged when not firing.
- Latency: all branches presented in cycle T -> p_srdy=1 in cycle T+2.
- Throughput: one joined word per cycle with continuous input and p_drdy=1.
- Ordering: each slot holds at most one item, so branch k can never run ahead by more than one transaction. Excess items are back-pressured via c_drdy[k]=0.
- Skew monitor:
  - partial = (|slot_vld) & ~all_vld.
  - partial=1: skew_cnt<=sat(skew_cnt+1). Otherwise skew_cnt<=0.
  - On the cycle partial falls: skew_max<=max(skew_max, skew_cnt).
  - Both counters saturate at 2^skew_w-1; they never wrap.
  - skew_clr=1: skew_max<=0. skew_clr takes priority over a simultaneous update.
- Boundary cases:
  - Output full (p_srdy=1, p_drdy=0) with all slots full: fire=0, every c_drdy=0, no data lost.
  - A branch asserting c_srdy while its slot is full and no fire occurs: held off; c_data must stay stable (standard srdy/drdy rule).
  - Reset mid-transaction: partially filled slots are discarded. No output is produced for that partial set.
- Protocol assertions (simulation only):
  - p_data stable while p_srdy & ~p_drdy.
  - No ld_i when slot_vld[i] & ~fire.

Decomposition:
- Package sd_join_pkg holds:
  - function sat_inc(value, width)
  - localparam SKEW_SAT
- One sub-module, sd_join_slot, instantiated join_cnt times via generate. Contains:
  - slot_vld/slot_data register
  - load/drain logic; inputs c_srdy, c_data, fire; outputs c_drdy, slot_vld, slot_data
- Top level holds: all_vld/fire, the output register, and the skew monitor.

Test Plan:
1. join_cnt=2, width=8; both branches send 0xA1/0xB2 in cycle 3 with p_drdy=1 -> p_srdy=1 in cycle 5, p_data=0xB2A1; skew_max stays 0.
2. Branch0 sends 0x11 at cycle 2, branch1 sends 0x22 at cycle 7 -> c_drdy[0]=0 for cycles 3-7 if branch0 offers again; p_data=0x2211 at cycle 9; skew_max=5.
3. Continuous streams on both branches, p_drdy=1 -> one p_srdy per cycle, values in order, c_drdy constantly 1.
4. Hold p_drdy=0 for 10 cycles with the output and both slots full -> c_drdy=00, p_data stable; release -> the next word appears the following cycle with nothing dropped.
5. skew_w=3; branch1 delayed 12 cycles -> skew_max=7 (saturated). Pulse skew_clr -> skew_max=0.
6. Assert rst low with slot0 full and slot1 empty -> all outputs zero immediately (asynchronous). After release, a fresh pair 0x33/0x44 yields p_data=0x4433 with no stale 0x?? from the old slot0.
